can_crc_check: RTL and testbench
================================

CAN_CRC_CHECK -- requirements
Module: can_crc_check

Interface
REQ-001 SHALL have parameter POLY, default 15'h4599, CAN 2.0 generator polynomial x^15+x^14+x^10+x^8+x^7+x^4+x^3+1, with the x^15 term implicit.
REQ-002 SHALL have clk, input, 1, the rising-edge clock.
REQ-003 SHALL have rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have bit_valid, input, 1, a one-cycle strobe at each receive sample point that qualifies every other bit input.
REQ-005 SHALL have din, input, 1, the destuffed receive bit, where 0 is dominant.
REQ-006 SHALL have sof, input, 1, which marks the current bit_valid bit as the start-of-frame bit.
REQ-007 SHALL have last_data, input, 1, which marks the current bit_valid bit as the final data-field bit.
REQ-008 SHALL have abort, input, 1, a synchronous frame abort (error frame or bus-off).
REQ-009 SHALL have busy, output, 1, which is high in every state except IDLE.
REQ-010 SHALL have crc_calc, output, 15, the running or final computed CRC.
REQ-011 SHALL have crc_rx, output, 15, the received CRC sequence.
REQ-012 SHALL have crc_done, output, 1, a one-cycle result strobe.
REQ-013 SHALL have crc_err, output, 1, the mismatch flag, valid while crc_done=1 and held until the next sof.
REQ-014 SHALL have delim_err, output, 1, the delimiter form-error flag, valid while crc_done=1 and held until the next sof.

Function
REQ-015 SHALL implement the states IDLE, CALC, RECV, DELIM and DONE.
REQ-016 SHALL, on bit_valid&sof in any state, clear crc_rx, crc_err and delim_err, load crc_calc with the SOF bit shifted into a zero register, and enter CALC.
REQ-017 SHALL ignore bit_valid&sof when din=1 (no dominant SOF) and remain in, or return to, IDLE.
REQ-018 SHALL perform each shift as: nxt=din^crc_calc[14]; crc_calc<=(crc_calc<<1)^(nxt?POLY:0); all results truncated to 15 bits.
REQ-019 SHALL, in CALC, shift every bit_valid bit into crc_calc.
REQ-020 SHALL, in CALC, on bit_valid&last_data, shift that bit, then enter RECV and clear the 4-bit counter cnt.
REQ-021 SHALL, in RECV, shift each bit_valid bit MSB-first into crc_rx (crc_rx<={crc_rx[13:0],din}), freeze crc_calc, and increment cnt.
REQ-022 SHALL, in RECV, leave for DELIM (or for DONE when DELIM is compiled out) on the bit_valid of the 15th bit (cnt=14).
REQ-023 SHALL, in DELIM, sample din on the next bit_valid, set delim_err=~din, and enter DONE.
REQ-024 SHALL, in DONE, assert crc_done for exactly one cycle with crc_err=(crc_calc!=crc_rx), then return to IDLE.
REQ-025 SHALL assert crc_done in the cycle after the clock edge that accepted the final required bit.
REQ-026 SHALL hold all state, counters and registers on cycles where bit_valid=0.
REQ-027 SHALL ignore last_data outside CALC.
REQ-028 SHALL, on abort in any state, enter IDLE the next cycle with no crc_done, leaving crc_calc and crc_rx unchanged.
REQ-029 SHALL give abort priority over sof when both occur in the same cycle.
REQ-030 SHALL treat a sof during RECV or DELIM as a resynchronisation per REQ-016, with no crc_done for the discarded frame.

Reset
REQ-031 SHALL, on rst_n=0, immediately force state=IDLE, cnt=0, crc_calc=0, crc_rx=0, crc_done=0, crc_err=0, delim_err=0 and busy=0, independent of clk.
REQ-032 SHALL, when reset occurs mid-frame, require a new sof before any further result.

Configuration
REQ-033 SHALL, when macro CAN_CRC_DELIM_CHECK_EN is defined, include the DELIM state and the delim_err output logic.
REQ-034 SHALL, when CAN_CRC_DELIM_CHECK_EN is undefined, omit DELIM, tie delim_err to 0, and assert crc_done one cycle after the 15th CRC bit.

Verification
REQ-035 SHALL cover: SOF=0, 8 zero data bits (last on the 8th), CRC field 15'h0000 -> crc_calc=15'h0000, crc_done with crc_err=0.
REQ-036 SHALL cover: SOF=0, one data bit 1 with last_data, CRC field 15'h4599, delimiter 1 -> crc_done with crc_err=0 and delim_err=0.
REQ-037 SHALL cover: the REQ-036 stimulus with CRC field 15'h4598 -> crc_done with crc_err=1 and crc_rx=15'h4598.
REQ-038 SHALL cover: the REQ-036 stimulus with delimiter 0, macro defined -> delim_err=1 and crc_err=0; macro undefined -> crc_done one bit earlier with delim_err=0.
REQ-039 SHALL cover: abort after the 7th CRC bit, then a full REQ-036 frame -> no crc_done for the aborted frame, one clean result for the second.
REQ-040 SHALL cover: rst_n pulsed low mid-CALC with bit_valid gaps of 3 cycles -> all outputs 0 immediately and busy=0 until the next valid sof.

Source files
------------

// File: rtl/can_crc_check.sv
// CAN CRC-15 calculation and check over a destuffed receive bitstream (SOF through data field).
// Define CAN_CRC_DELIM_CHECK_EN to add the CRC-delimiter form check (DELIM state and delim_err).
module can_crc_check #(
  parameter logic [14:0] POLY = 15'h4599
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_valid,
  input  logic        din,
  input  logic        sof,
  input  logic        last_data,
  input  logic        abort,
  output logic        busy,
  output logic [14:0] crc_calc,
  output logic [14:0] crc_rx,
  output logic        crc_done,
  output logic        crc_err,
  output logic        delim_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CALC  = 3'd1;
  localparam logic [2:0] ST_RECV  = 3'd2;
`ifdef CAN_CRC_DELIM_CHECK_EN
  localparam logic [2:0] ST_DELIM = 3'd3;
`endif
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic [14:0] crc_shift;
  logic [14:0] crc_rx_shift;

  always_comb begin
    crc_shift    = {crc_calc[13:0], 1'b0} ^ ((din ^ crc_calc[14]) ? POLY : 15'h0000);
    crc_rx_shift = {crc_rx[13:0], din};
  end

  assign busy     = (state != ST_IDLE);
  assign crc_done = (state == ST_DONE);

`ifdef CAN_CRC_DELIM_CHECK_EN
  logic delim_err_reg;
  assign delim_err = delim_err_reg;
`else
  assign delim_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      crc_calc <= 15'h0000;
      crc_rx   <= 15'h0000;
      crc_err  <= 1'b0;
`ifdef CAN_CRC_DELIM_CHECK_EN
      delim_err_reg <= 1'b0;
`endif
    end else if (abort) begin
      state <= ST_IDLE;
    end else if (bit_valid && sof) begin
      if (!din) begin
        // A dominant SOF shifted into a cleared register leaves it cleared.
        state    <= ST_CALC;
        cnt      <= 4'd0;
        crc_calc <= 15'h0000;
        crc_rx   <= 15'h0000;
        crc_err  <= 1'b0;
`ifdef CAN_CRC_DELIM_CHECK_EN
        delim_err_reg <= 1'b0;
`endif
      end else begin
        state <= ST_IDLE;
      end
    end else begin
      case (state)
        ST_CALC: begin
          if (bit_valid) begin
            crc_calc <= crc_shift;
            if (last_data) begin
              state <= ST_RECV;
              cnt   <= 4'd0;
            end
          end
        end
        ST_RECV: begin
          if (bit_valid) begin
            crc_rx <= crc_rx_shift;
            cnt    <= cnt + 4'd1;
            if (cnt == 4'd14) begin
`ifdef CAN_CRC_DELIM_CHECK_EN
              state <= ST_DELIM;
`else
              state   <= ST_DONE;
              crc_err <= (crc_calc != crc_rx_shift);
`endif
            end
          end
        end
`ifdef CAN_CRC_DELIM_CHECK_EN
        ST_DELIM: begin
          if (bit_valid) begin
            delim_err_reg <= ~din;
            crc_err       <= (crc_calc != crc_rx);
            state         <= ST_DONE;
          end
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_crc_check.sv
// Scoreboard bench for can_crc_check: reference CRC by polynomial long division, monitor pops on crc_done.
module tb_can_crc_check;
  localparam logic [14:0] POLY = 15'h4599;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_valid = 1'b0;
  logic        din = 1'b1;
  logic        sof = 1'b0;
  logic        last_data = 1'b0;
  logic        abort = 1'b0;
  logic        busy, crc_done, crc_err, delim_err;
  logic [14:0] crc_calc, crc_rx;

  typedef struct {
    logic [14:0] calc;
    logic [14:0] rx;
    logic        err;
    logic        derr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  int   cycle_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  can_crc_check #(.POLY(POLY)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .din(din), .sof(sof),
    .last_data(last_data), .abort(abort), .busy(busy), .crc_calc(crc_calc),
    .crc_rx(crc_rx), .crc_done(crc_done), .crc_err(crc_err), .delim_err(delim_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Remainder of (SOF,data) * x^15 divided by x^15 + POLY, MSB first.
  function automatic logic [14:0] ref_crc(input int len, input logic [63:0] data);
    bit          a[0:95];
    logic [15:0] gen;
    logic [14:0] r;
    int          n;
    gen = {1'b1, POLY};
    n = len + 1;
    for (int i = 0; i < 96; i++) a[i] = 1'b0;
    for (int i = 0; i < len; i++) a[i+1] = data[i];
    for (int i = 0; i < n; i++)
      if (a[i]) for (int j = 0; j < 16; j++) a[i+j] ^= gen[15-j];
    for (int k = 0; k < 15; k++) r[14-k] = a[n+k];
    return r;
  endfunction

  task automatic idle();
    @(negedge clk);
    bit_valid = 1'b0; sof = 1'b0; last_data = 1'b0; din = 1'b1; abort = 1'b0;
  endtask

  task automatic drive_bit(input bit b, input bit s, input bit l, input int gap, input bit push_it);
    @(negedge clk);
    din = b; sof = s; last_data = l; bit_valid = 1'b1; abort = 1'b0;
    if (push_it) begin
      pend.cyc = cycle_cnt + 1;
      exp_q.push_back(pend);
    end
    repeat (gap) begin
      @(negedge clk);
      bit_valid = 1'b0; din = 1'($urandom); sof = 1'($urandom); last_data = 1'($urandom);
    end
  endtask

  task automatic abort_pulse();
    @(negedge clk);
    bit_valid = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
  endtask

  // trunc >= 0 stops the frame after that many bits (before its last required bit).
  task automatic send_frame(input int len, input logic [63:0] data, input logic [14:0] crc_field,
                            input bit delim, input int trunc, input bit use_abort, input int max_gap);
    int total, final_idx, sent;
    bit b, s, l;
    pend.calc = ref_crc(len, data);
    pend.rx   = crc_field;
    pend.err  = (crc_field != pend.calc);
`ifdef CAN_CRC_DELIM_CHECK_EN
    pend.derr = ~delim;
    final_idx = len + 16;
`else
    pend.derr = 1'b0;
    final_idx = len + 15;
`endif
    total = len + 17;
    sent = (trunc >= 0 && trunc <= final_idx) ? trunc : total;
    for (int i = 0; i < sent; i++) begin
      if (i == 0) begin
        b = 1'b0; s = 1'b1; l = 1'b0;
      end else if (i <= len) begin
        b = data[i-1]; s = 1'b0; l = (i == len);
      end else if (i <= len + 15) begin
        b = crc_field[14-(i-len-1)]; s = 1'b0; l = 1'($urandom);
      end else begin
        b = delim; s = 1'b0; l = 1'($urandom);
      end
      drive_bit(b, s, l, $urandom_range(0, max_gap), (i == final_idx));
    end
    if (sent != total && use_abort) abort_pulse();
    idle();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && crc_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: crc_done=1 at cycle %0d, expected no result", cycle_cnt);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cycle_cnt, e.cyc);
        chk("crc_calc", 32'(crc_calc), 32'(e.calc));
        chk("crc_rx", 32'(crc_rx), 32'(e.rx));
        chk("crc_err", 32'(crc_err), 32'(e.err));
        chk("delim_err", 32'(delim_err), 32'(e.derr));
        $display("frame done cyc=%0d calc=%h rx=%h err=%0b derr=%0b",
                 cycle_cnt, crc_calc, crc_rx, crc_err, delim_err);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_crc_calc"}, 32'(crc_calc), 0);
    chk({tag, "_crc_rx"}, 32'(crc_rx), 0);
    chk({tag, "_crc_done"}, 32'(crc_done), 0);
    chk({tag, "_crc_err"}, 32'(crc_err), 0);
    chk({tag, "_delim_err"}, 32'(delim_err), 0);
  endtask

  initial begin
    int          len, trunc;
    logic [63:0] d;
    logic [14:0] cf, good;
    bit          dl, ab;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Zero data field, zero CRC
    send_frame(8, 64'h0, 15'h0000, 1'b1, -1, 1'b0, 1);
    repeat (3) idle();
    // Single recessive data bit, correct CRC
    send_frame(1, 64'h1, 15'h4599, 1'b1, -1, 1'b0, 2);
    // Delimiter dominant
    send_frame(1, 64'h1, 15'h4599, 1'b0, -1, 1'b0, 0);
    // Abort after 7th CRC bit, then a clean frame
    send_frame(1, 64'h1, 15'h4599, 1'b1, 9, 1'b1, 1);
    send_frame(1, 64'h1, 15'h4599, 1'b1, -1, 1'b0, 1);
    // Corrupted CRC field; error flag must persist afterwards
    send_frame(1, 64'h1, 15'h4598, 1'b1, -1, 1'b0, 0);
    repeat (5) idle();
    chk("err_hold", 32'(crc_err), 1);
    chk("rx_hold", 32'(crc_rx), 32'h4598);

    // Recessive SOF is not a frame start, in IDLE or mid-frame
    drive_bit(1'b1, 1'b1, 1'b0, 0, 1'b0);
    idle();
    chk("recessive_sof_idle", 32'(busy), 0);
    drive_bit(1'b0, 1'b1, 1'b0, 0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0, 0, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0, 0, 1'b0);
    idle();
    chk("recessive_sof_calc", 32'(busy), 0);

    // Abort wins over a simultaneous dominant SOF
    @(negedge clk);
    bit_valid = 1'b1; sof = 1'b1; din = 1'b0; abort = 1'b1;
    idle();
    chk("abort_over_sof", 32'(busy), 0);

    // Asynchronous reset mid-CALC with 3-cycle bit gaps
    drive_bit(1'b0, 1'b1, 1'b0, 3, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0, 3, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0, 3, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0, 1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'($urandom), 1'b0, (i == 2), 3, 1'b0);
      chk("post_reset_busy", 32'(busy), 0);
    end
    idle();
    send_frame(1, 64'h1, 15'h4599, 1'b1, -1, 1'b0, 3);

    // Randomized frames with occasional truncation by abort or resynchronising SOF
    for (int f = 0; f < 150; f++) begin
      len  = $urandom_range(1, 64);
      d    = {$urandom, $urandom};
      good = ref_crc(len, d);
      case ($urandom_range(0, 2))
        0: cf = good;
        1: cf = good ^ (15'h1 << $urandom_range(0, 14));
        default: cf = 15'($urandom);
      endcase
      dl    = ($urandom_range(0, 3) != 0);
      trunc = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len + 16) : -1;
      ab    = 1'($urandom);
      send_frame(len, d, cf, dl, trunc, ab, $urandom_range(0, 3));
    end

    repeat (20) idle();
    chk("pending_results", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
